// File: rtl/sig_mac_accum_p_if.sv
// Operand/result bundle for sig_mac_accum_p: operand pair with framing in,
// completed vector sum with overflow flag out.
interface sig_mac_accum_p_if #(
  parameter int A_W   = 9,
  parameter int B_W   = 9,
  parameter int ACC_W = 19
);
  logic                    in_valid;
  logic                    in_last;
  logic signed [A_W-1:0]   dataa;
  logic signed [B_W-1:0]   datab;
  logic                    out_valid;
  logic signed [ACC_W-1:0] result;
  logic                    ovf;

  modport master (
    output in_valid, in_last, dataa, datab,
    input  out_valid, result, ovf
  );

  modport slave (
    input  in_valid, in_last, dataa, datab,
    output out_valid, result, ovf
  );
endinterface

// File: rtl/sig_mac_accum_p.sv
// Pipelined signed multiply-accumulate: S1 operand regs, S2 product reg,
// S3 vector accumulator with saturating or wrapping arithmetic.
module sig_mac_accum_p #(
  parameter int A_W   = 9,
  parameter int B_W   = 9,
  parameter int ACC_W = 19,
  parameter int SAT   = 1
) (
  input  logic              clk,
  input  logic              aclr_n,
  input  logic              clken,
  input  logic              sload,
  sig_mac_accum_p_if.slave  bus
);
  localparam int P_W = A_W + B_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  if (ACC_W < A_W + B_W) begin : g_bad_width
    $error("sig_mac_accum_p: ACC_W must be >= A_W+B_W");
  end

  logic signed [A_W-1:0]   a_q;
  logic signed [B_W-1:0]   b_q;
  logic signed [P_W-1:0]   prod_q;
  logic [1:0]              vld_pipe;   // [0]=S1 valid, [1]=S2 valid
  logic [1:0]              last_pipe;
  logic signed [ACC_W-1:0] acc;
  logic                    first;
  logic                    ovf_acc;
  logic                    out_valid_q;
  logic signed [ACC_W-1:0] result_q;
  logic                    ovf_q;

  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W:0]   sum;
  logic                    ovf_now;
  logic signed [ACC_W-1:0] acc_nxt;
  logic                    ovf_nxt;

  always_comb begin
    base    = first ? '0 : acc;
    sum     = (ACC_W+1)'(base) + (ACC_W+1)'(prod_q);
    ovf_now = sum[ACC_W] ^ sum[ACC_W-1];
    ovf_nxt = first ? ovf_now : (ovf_acc | ovf_now);
    acc_nxt = sum[ACC_W-1:0];
    if (SAT != 0) begin
      // once clamped, the rest of the vector stays pinned at the rail
      if (!first && ovf_acc)
        acc_nxt = acc;
      else if (ovf_now)
        acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      vld_pipe    <= '0;
      last_pipe   <= '0;
      acc         <= '0;
      first       <= 1'b1;
      ovf_acc     <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
    end else if (clken) begin
      if (sload) begin
        vld_pipe    <= '0;
        acc         <= '0;
        ovf_acc     <= 1'b0;
        out_valid_q <= 1'b0;
        first       <= 1'b1;
      end else begin
        a_q         <= bus.dataa;
        b_q         <= bus.datab;
        prod_q      <= P_W'(a_q) * P_W'(b_q);
        vld_pipe    <= {vld_pipe[0], bus.in_valid};
        last_pipe   <= {last_pipe[0], bus.in_valid & bus.in_last};
        out_valid_q <= vld_pipe[1] & last_pipe[1];
        if (vld_pipe[1]) begin
          acc     <= acc_nxt;
          ovf_acc <= ovf_nxt;
          first   <= last_pipe[1];
          if (last_pipe[1]) begin
            result_q <= acc_nxt;
            ovf_q    <= ovf_nxt;
          end
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_sig_mac_accum_p.sv
// Directed bench: SAT=1 and SAT=0 instances share stimulus; an integer
// reference model pushes expected sums to a queue checked on out_valid.
module tb_sig_mac_accum_p;
  localparam int A_W = 9, B_W = 9, ACC_W = 19;
  localparam longint MAXV = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (ACC_W-1));

  typedef struct {
    longint res_s;
    longint res_w;
    bit     ovf;
    int     due;
  } exp_t;

  logic clk = 1'b0, aclr_n = 1'b0, clken = 1'b1, sload = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0;
  logic signed [A_W-1:0] da = '0;
  logic signed [B_W-1:0] db = '0;

  int errors = 0, checks = 0, cyc = 0;
  exp_t q[$];

  longint m_s = 0, m_w = 0;
  bit m_first = 1'b1, m_ovf = 1'b0, m_clamped = 1'b0;
  longint last_res_s = 0;

  sig_mac_accum_p_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) bus_s ();
  sig_mac_accum_p_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) bus_w ();

  assign bus_s.in_valid = in_valid;
  assign bus_s.in_last  = in_last;
  assign bus_s.dataa    = da;
  assign bus_s.datab    = db;
  assign bus_w.in_valid = in_valid;
  assign bus_w.in_last  = in_last;
  assign bus_w.dataa    = da;
  assign bus_w.datab    = db;

  sig_mac_accum_p #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .SAT(1)) dut_s (
    .clk(clk), .aclr_n(aclr_n), .clken(clken), .sload(sload), .bus(bus_s));
  sig_mac_accum_p #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .SAT(0)) dut_w (
    .clk(clk), .aclr_n(aclr_n), .clken(clken), .sload(sload), .bus(bus_w));

  always #5 clk = ~clk;

  always @(posedge clk) if (aclr_n && clken) cyc <= cyc + 1;

  task automatic chk(string tag, logic signed [63:0] got, logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap(longint v);
    longint x;
    x = v & ((64'sd1 <<< ACC_W) - 1);
    if (x > MAXV) x = x - (64'sd1 <<< ACC_W);
    return x;
  endfunction

  function automatic void model_reset();
    m_first = 1'b1;
  endfunction

  // one pair through the reference model; pushes an expectation on last
  function automatic void model(int a, int b, bit last, int due);
    longint p, ss, sw;
    bit o;
    exp_t e;
    p  = longint'(a) * longint'(b);
    ss = (m_first ? 0 : m_s) + p;
    sw = (m_first ? 0 : m_w) + p;
    o  = (sw > MAXV) || (sw < MINV);
    m_ovf = m_first ? o : (m_ovf | o);
    if (!(!m_first && m_clamped)) begin
      if (ss > MAXV)      begin m_s = MAXV; m_clamped = 1'b1; end
      else if (ss < MINV) begin m_s = MINV; m_clamped = 1'b1; end
      else                begin m_s = ss;   m_clamped = 1'b0; end
    end
    m_w = wrap(sw);
    m_first = last;
    if (last) begin
      e.res_s = m_s; e.res_w = m_w; e.ovf = m_ovf; e.due = due;
      q.push_back(e);
      last_res_s = m_s;
    end
  endfunction

  // drive one pair; it is sampled at the next rising edge
  task automatic send(int a, int b, bit last);
    in_valid = 1'b1; in_last = last;
    da = A_W'(a); db = B_W'(b);
    @(posedge clk); #1;
    model(a, b, last, cyc + 2);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (aclr_n && clken && (bus_s.out_valid || bus_w.out_valid)) begin
      exp_t e;
      chk("valid_align", bus_w.out_valid, bus_s.out_valid);
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_valid: observed=%0d expected=%0d", bus_s.result, 0);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("result_sat", bus_s.result, e.res_s);
        chk("result_wrap", bus_w.result, e.res_w);
        chk("ovf_sat", bus_s.ovf, e.ovf);
        chk("ovf_wrap", bus_w.ovf, e.ovf);
        chk("latency", cyc, e.due);
      end
    end
  end

  initial begin
    // reset held with random activity on the inputs
    aclr_n = 1'b0;
    repeat (4) begin
      in_valid = 1'($urandom); in_last = 1'($urandom);
      da = A_W'($urandom); db = B_W'($urandom);
      @(posedge clk); #1;
      chk("rst_valid", bus_s.out_valid, 0);
      chk("rst_result", bus_s.result, 0);
      chk("rst_ovf", bus_w.ovf, 0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    aclr_n = 1'b1;
    send(1, 1, 1);
    idle(3);

    // basic vector
    send(3, 4, 0); send(-5, 6, 0); send(7, -2, 1);
    idle(3);

    // back-to-back single-element vectors
    send(2, 3, 1); send(1, 1, 1); send(-256, 255, 1);
    idle(3);

    // overflow: SAT clamps, wrap rolls over; next vector starts clean
    repeat (4) send(-256, -256, 0);
    send(-256, -256, 1);
    send(1, 1, 1);
    idle(3);

    // stall then abort
    send(10, 10, 0); send(20, 20, 0);
    clken = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("stall_valid", bus_s.out_valid, 0);
      chk("stall_result", bus_s.result, last_res_s);
    end
    clken = 1'b1; sload = 1'b1;
    @(posedge clk); #1;
    sload = 1'b0;
    model_reset();
    idle(3);
    chk("abort_result", bus_s.result, last_res_s);
    send(2, 2, 1);
    idle(3);

    // asynchronous reset mid-vector
    send(7, 7, 0); send(8, 8, 0);
    aclr_n = 1'b0;
    #1;
    chk("arst_valid", bus_s.out_valid, 0);
    chk("arst_result", bus_s.result, 0);
    chk("arst_result_w", bus_w.result, 0);
    @(posedge clk); #1;
    aclr_n = 1'b1;
    model_reset();
    send(5, 5, 1);

    // drain with a bounded wait
    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
    chk("drain_pending", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sig_mac_accum_p.md
# sig_mac_accum_p

Parametrised, pipelined signed multiply-accumulate engine for dot-product style workloads in the datapath. It multiplies signed operand pairs, accumulates them over a vector framed by `in_last`, and emits one result per vector with a valid pulse. Compared with the single-width free-running accumulator, it adds:

- parametric widths
- input/product pipelining
- vector framing and result handshake
- selectable saturating or wrapping arithmetic
- a sticky overflow flag

## Interface
- `A_W`, 9, signed width of `dataa`
- `B_W`, 9, signed width of `datab`
- `ACC_W`, 19, accumulator/result width; must satisfy `ACC_W >= A_W+B_W`, otherwise elaboration error
- `SAT`, 1, 1 = saturate on overflow, 0 = two's-complement wrap

Ports:
- `clk`  in  1  clock, all state on rising edge
- `aclr_n`  in  1  asynchronous active-low reset
- `clken`  in  1  global clock enable; low = every register holds
- `sload`  in  1  synchronous clear/abort of current vector (qualified by `clken`)
- `in_valid`  in  1  operand pair valid
- `in_last`  in  1  marks final pair of a vector (qualified by `in_valid`)
- `dataa`  in  `A_W`  signed operand A
- `datab`  in  `B_W`  signed operand B
- `out_valid`  out  1  one-cycle pulse: `result` holds a completed vector sum
- `result`  out  `ACC_W`  signed vector sum, held until next `out_valid`
- `ovf`  out  1  overflow occurred in the vector reported by `result`

## Operation
- Three register stages, all advancing only when `clken`=1:
  - **S1:** register `dataa`, `datab`, `in_valid`, `in_last`.
  - **S2:** register the signed product (`A_W+B_W` bits) plus the valid and last bits.
  - **S3:** accumulate.
- Start-of-vector flag `first`:
  - Set by reset, by `sload`, and by each accumulation carrying `last`.
  - Cleared by any other accumulation.
- S3 on a valid product:
  - Base is 0 if `first`, else `acc`.
  - `sum` = base + sign-extended product, computed in `ACC_W+1` bits.
  - Overflow condition: `sum` is not representable in `ACC_W` bits.
  - `SAT`=1: `acc` clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and keeps clamping for the rest of the vector.
  - `SAT`=0: `acc` takes the low `ACC_W` bits.
- Sticky overflow `ovf_acc`:
  - Set on any overflow in the vector.
  - Loaded fresh (not OR'd) on the first element of each vector.
- On an accumulation carrying `last`:
  - `result` <= new `acc` value.
  - `ovf` <= final sticky value.
  - `out_valid` <= 1.
  - Otherwise `out_valid` <= 0.
- `sload` (with `clken`=1) has priority over everything:
  - Clears the S1/S2 valid bits, `acc`, `ovf_acc` and `out_valid`.
  - Sets `first`.
  - The input pair sampled in the same cycle is discarded.
  - `result` and `ovf` keep their last reported values.
- Single-element vectors (`in_last` on the first pair) are legal. Back-to-back vectors need no idle cycle.
- Reset (`aclr_n` low, any time, including mid-vector) forces immediately:
  - `out_valid`=0, `result`=0, `ovf`=0.
  - `acc`=0, all pipeline valid bits 0, `first`=1.
  - In-flight data is lost.

## Timing
- Latency: a pair sampled at enabled edge k reaches S2 at k+1 and is accumulated at k+2.
- `out_valid`/`result` become visible after edge k+2 for the last pair.
- Throughput: one pair per enabled cycle.
- `clken`=0 freezes all state, including `out_valid`. A pulse therefore stretches over stalled cycles; consumers qualify `out_valid` with `clken`.
- Reset deassertion: the first sample is taken at the first rising edge with `aclr_n`=1 and `clken`=1.
- Outputs come directly from flops; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold `aclr_n`=0 while driving random inputs with `clken`=1 -> `out_valid`=0, `result`=0, `ovf`=0. Release, then send pair (1,1) with last -> `result`=1 two edges after it is sampled.
- **Basic vector:** (3,4), (-5,6), (7,-2) on consecutive cycles, last on the third -> one `out_valid` pulse 2 edges after the third, `result`=-32, `ovf`=0.
- **Back-to-back:** (2,3) last, then (1,1) last, then (-256,255) last -> `out_valid` high three consecutive cycles with `result` 6, 1, -65280.
- **Overflow:** five pairs (-256,-256) with last on the fifth (sum 327680).
  - `SAT`=1 -> `result`=262143, `ovf`=1.
  - `SAT`=0 -> `result`=-196608, `ovf`=1.
  - A following vector (1,1) last -> `result`=1, `ovf`=0.
- **Stall/abort:** send 2 pairs of a 3-pair vector, drop `clken` for 4 cycles -> no state change. Assert `sload` -> no `out_valid`. Then send (2,2) last -> `result`=4 (no residue from the aborted vector).
- **Reset mid-vector:** pulse `aclr_n` low between pairs 2 and 3 of a vector -> outputs zero immediately. The next vector (5,5) last -> `result`=25.
